// File: rtl/sd_pkg.sv
// Shared constants and state types for the UART-to-SD sector packer.
package sd_pkg;

    localparam int unsigned SECTOR_BYTES = 512;

    // Lifecycle of one ping-pong bank.
    typedef enum logic [1:0] {
        BankEmpty,
        BankFilling,
        BankFull,
        BankReading
    } bank_state_e;

    typedef enum logic {
        WFill,
        WWait
    } wr_state_e;

    typedef enum logic {
        RIdle,
        RSend
    } rd_state_e;

endpackage

// File: rtl/sd_sector_ram.sv
// Simple dual-port byte RAM holding both sector banks; address is {bank, ptr}.
module sd_sector_ram #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [2**ADDR_W];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; gives the one-cycle read latency seen at the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sd_uart_sector_packer.sv
// Packs UART bytes into fixed-size sectors through a two-bank ping-pong buffer,
// flushing partial sectors after an idle timeout and dropping bytes when both
// banks are occupied.
module sd_uart_sector_packer #(
    parameter int unsigned SECTOR_BYTES   = sd_pkg::SECTOR_BYTES,
    parameter int unsigned TIMEOUT_CYCLES = 20_000_000,
    parameter logic [7:0]  PAD_BYTE       = 8'h00
) (
    input  logic                              sys_clk,
    input  logic                              sys_rst_n,
    input  logic [7:0]                        pi_data,
    input  logic                              pi_flag,
    output logic                              sec_ready,
    output logic [$clog2(SECTOR_BYTES+1)-1:0] sec_fill,
    input  logic                              rd_en,
    output logic [7:0]                        rd_data,
    output logic                              overflow,
    output logic [15:0]                       drop_cnt
);

    import sd_pkg::*;

    localparam int unsigned PTR_W  = $clog2(SECTOR_BYTES);
    localparam int unsigned FILL_W = $clog2(SECTOR_BYTES + 1);
    localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(SECTOR_BYTES - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SECTOR_BYTES);

    wr_state_e         wr_state_q, wr_state_d;
    rd_state_e         rd_state_q, rd_state_d;
    bank_state_e       bank_q [2];
    bank_state_e       bank_d [2];
    logic [FILL_W-1:0] fill_q [2];
    logic [FILL_W-1:0] fill_d [2];
    logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_addr_q, rd_addr_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       drop_q, drop_d;
    logic              pad_q, pad_d;
    logic              close;
    logic [FILL_W-1:0] close_fill;
    logic              ram_we, ram_re;
    logic [7:0]        ram_rdata;

    // Next state for both FSMs; they only ever touch different banks.
    always_comb begin
        wr_state_d = wr_state_q;
        rd_state_d = rd_state_q;
        bank_d     = bank_q;
        fill_d     = fill_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        wr_ptr_d   = wr_ptr_q;
        rd_addr_d  = rd_addr_q;
        timer_d    = timer_q;
        overflow_d = 1'b0;
        drop_d     = drop_q;
        pad_d      = pad_q;
        close      = 1'b0;
        close_fill = FILL_FULL;
        ram_we     = 1'b0;
        ram_re     = 1'b0;

        if (pi_flag) begin
            timer_d = '0;
        end else if (timer_q != TMR_LAST) begin
            timer_d = timer_q + 1'b1;
        end

        unique case (wr_state_q)
            WFill: begin
                if (pi_flag) begin
                    ram_we = 1'b1;
                    if (wr_ptr_q == PTR_LAST) begin
                        close = 1'b1;
                    end else begin
                        wr_ptr_d          = wr_ptr_q + 1'b1;
                        bank_d[wr_bank_q] = BankFilling;
                    end
                end else if (timer_q == TMR_LAST && wr_ptr_q != '0) begin
                    // Idle flush of a partial sector.
                    close      = 1'b1;
                    close_fill = FILL_W'(wr_ptr_q);
                    timer_d    = '0;
                end
                if (close) begin
                    bank_d[wr_bank_q] = BankFull;
                    fill_d[wr_bank_q] = close_fill;
                    wr_bank_d         = ~wr_bank_q;
                    wr_ptr_d          = '0;
                    if (bank_q[~wr_bank_q] != BankEmpty) begin
                        wr_state_d = WWait;
                    end
                end
            end
            WWait: begin
                if (pi_flag) begin
                    overflow_d = 1'b1;
                    if (drop_q != 16'hFFFF) begin
                        drop_d = drop_q + 16'd1;
                    end
                end
                if (bank_q[wr_bank_q] == BankEmpty) begin
                    wr_state_d = WFill;
                end
            end
        endcase

        unique case (rd_state_q)
            RIdle: begin
                if (bank_q[rd_bank_q] == BankFull) begin
                    bank_d[rd_bank_q] = BankReading;
                    rd_addr_d         = '0;
                    rd_state_d        = RSend;
                end
            end
            RSend: begin
                if (rd_en) begin
                    ram_re    = 1'b1;
                    pad_d     = FILL_W'(rd_addr_q) >= fill_q[rd_bank_q];
                    rd_addr_d = rd_addr_q + 1'b1;
                    if (rd_addr_q == PTR_LAST) begin
                        bank_d[rd_bank_q] = BankEmpty;
                        rd_bank_d         = ~rd_bank_q;
                        rd_state_d        = RIdle;
                    end
                end
            end
        endcase
    end

    // State registers; reset discards any buffered sector.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_state_q <= WFill;
            rd_state_q <= RIdle;
            bank_q     <= '{default: BankEmpty};
            fill_q     <= '{default: '0};
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_addr_q  <= '0;
            timer_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            pad_q      <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            bank_q     <= bank_d;
            fill_q     <= fill_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_addr_q  <= rd_addr_d;
            timer_q    <= timer_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            pad_q      <= pad_d;
        end
    end

    sd_sector_ram #(
        .ADDR_W (PTR_W + 1)
    ) u_ram (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .we    (ram_we),
        .waddr ({wr_bank_q, wr_ptr_q}),
        .wdata (pi_data),
        .re    (ram_re),
        .raddr ({rd_bank_q, rd_addr_q}),
        .rdata (ram_rdata)
    );

    // Output decode.
    always_comb begin
        sec_ready = (rd_state_q == RSend);
        sec_fill  = sec_ready ? fill_q[rd_bank_q] : '0;
        rd_data   = pad_q ? PAD_BYTE : ram_rdata;
        overflow  = overflow_q;
        drop_cnt  = drop_q;
    end

endmodule

// File: tb/tb_sd_uart_sector_packer.sv
// Directed bench for the sector packer with a short idle timeout.
module tb_sd_uart_sector_packer;

    localparam int SB  = 512;
    localparam int TO  = 100;
    localparam logic [7:0] PAD = 8'hEE;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pi_data = '0;
    logic        pi_flag = 1'b0;
    logic        sec_ready;
    logic [9:0]  sec_fill;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_data;
    logic        overflow;
    logic [15:0] drop_cnt;

    int n_total = 0;
    int n_pass  = 0;
    logic [7:0] exp_bytes [SB];

    always #5 clk = ~clk;

    sd_uart_sector_packer #(
        .SECTOR_BYTES   (SB),
        .TIMEOUT_CYCLES (TO),
        .PAD_BYTE       (PAD)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .pi_data   (pi_data),
        .pi_flag   (pi_flag),
        .sec_ready (sec_ready),
        .sec_fill  (sec_fill),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] pat(input int i, input int seed);
        return 8'((i + (i >> 8) * 37 + seed) & 255);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        pi_data = b;
        pi_flag = 1'b1;
        tick();
        pi_flag = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n = 0;
        while (!sec_ready && n < budget) begin
            tick();
            n++;
        end
        check({tag, " ready"}, 32'(sec_ready), 32'd1);
    endtask

    task automatic read_sector(input string tag, input int nreal);
        for (int i = 0; i < SB; i++) begin
            rd_en = 1'b1;
            tick();
            check($sformatf("%s[%0d]", tag, i), 32'(rd_data),
                  32'((i < nreal) ? exp_bytes[i] : PAD));
        end
        rd_en = 1'b0;
    endtask

    initial begin
        int ovf_n;

        // Reset state
        idle(2);
        check("rst sec_ready", 32'(sec_ready), 32'd0);
        check("rst sec_fill", 32'(sec_fill), 32'd0);
        check("rst rd_data", 32'(rd_data), 32'd0);
        check("rst overflow", 32'(overflow), 32'd0);
        check("rst drop_cnt", 32'(drop_cnt), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Full sector, one byte every 10 cycles
        for (int i = 0; i < SB; i++) exp_bytes[i] = 8'(i);
        for (int i = 0; i < SB - 1; i++) begin
            send_byte(exp_bytes[i]);
            idle(9);
        end
        send_byte(exp_bytes[SB-1]);
        check("full latency+1", 32'(sec_ready), 32'd0);
        tick();
        check("full latency+2", 32'(sec_ready), 32'd1);
        check("full sec_fill", 32'(sec_fill), 32'd512);
        read_sector("full data", SB);
        check("full ready fall", 32'(sec_ready), 32'd0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("ignored rd_en", 32'(rd_data), 32'hFF);

        // Partial flush after idle timeout
        for (int i = 0; i < 5; i++) begin
            exp_bytes[i] = 8'hA1 + 8'(i);
            send_byte(exp_bytes[i]);
        end
        idle(TO);
        check("flush not early", 32'(sec_ready), 32'd0);
        tick();
        check("flush ready", 32'(sec_ready), 32'd1);
        check("flush sec_fill", 32'(sec_fill), 32'd5);
        read_sector("flush data", 5);

        // Overflow: 1100 back-to-back bytes, no reads
        ovf_n = 0;
        for (int i = 0; i < 1100; i++) begin
            send_byte(pat(i, 0));
            if (overflow) ovf_n++;
        end
        check("ovf pulses", 32'(ovf_n), 32'd76);
        check("ovf drop_cnt", 32'(drop_cnt), 32'd76);
        wait_ready("ovf s0", 10);
        for (int i = 0; i < SB; i++) exp_bytes[i] = pat(i, 0);
        read_sector("ovf s0", SB);
        check("ovf gap", 32'(sec_ready), 32'd0);
        // Bank 0 frees now: this byte lands on the free cycle and is dropped
        send_byte(8'h11);
        check("free-cycle ovf", 32'(overflow), 32'd1);
        check("free-cycle drop", 32'(drop_cnt), 32'd77);
        check("ovf s1 ready", 32'(sec_ready), 32'd1);
        // One cycle later the byte is stored
        send_byte(8'h22);
        check("free+1 ovf", 32'(overflow), 32'd0);
        check("free+1 drop", 32'(drop_cnt), 32'd77);
        check("ovf s1 fill", 32'(sec_fill), 32'd512);
        for (int i = 0; i < SB; i++) exp_bytes[i] = pat(SB + i, 0);
        read_sector("ovf s1", SB);
        check("s1 gap", 32'(sec_ready), 32'd0);
        tick();
        check("stored byte ready", 32'(sec_ready), 32'd1);
        check("stored byte fill", 32'(sec_fill), 32'd1);
        exp_bytes[0] = 8'h22;
        read_sector("stored byte", 1);

        // Concurrent fill of one bank while reading the other
        for (int i = 0; i < SB; i++) begin
            exp_bytes[i] = pat(i, 5);
            send_byte(exp_bytes[i]);
        end
        fork
            begin
                for (int i = 0; i < SB; i++) send_byte(pat(i, 9));
            end
            begin
                wait_ready("conc A", 10);
                check("conc A fill", 32'(sec_fill), 32'd512);
                read_sector("conc A", SB);
            end
        join
        check("conc drops", 32'(drop_cnt), 32'd77);
        check("conc gap", 32'(sec_ready), 32'd0);
        wait_ready("conc B", 10);
        check("conc B fill", 32'(sec_fill), 32'd512);
        for (int i = 0; i < SB; i++) exp_bytes[i] = pat(i, 9);
        read_sector("conc B", SB);

        // Byte arriving on the timeout cycle suppresses the flush
        exp_bytes[0] = 8'h3C;
        exp_bytes[1] = 8'hC3;
        send_byte(exp_bytes[0]);
        idle(TO - 1);
        send_byte(exp_bytes[1]);
        idle(TO);
        check("tmo no flush", 32'(sec_ready), 32'd0);
        tick();
        check("tmo later flush", 32'(sec_ready), 32'd1);
        check("tmo fill", 32'(sec_fill), 32'd2);
        read_sector("tmo data", 2);

        // Sector completed exactly on the timeout cycle
        for (int i = 0; i < SB; i++) exp_bytes[i] = pat(i, 2);
        for (int i = 0; i < SB - 1; i++) send_byte(exp_bytes[i]);
        idle(TO - 1);
        send_byte(exp_bytes[SB-1]);
        tick();
        check("tmo-full ready", 32'(sec_ready), 32'd1);
        check("tmo-full fill", 32'(sec_fill), 32'd512);
        read_sector("tmo-full data", SB);
        idle(TO + 50);
        check("tmo-full single", 32'(sec_ready), 32'd0);

        // Reset mid-sector
        for (int i = 0; i < 300; i++) send_byte(pat(i, 1));
        rst_n = 1'b0;
        #1;
        check("mid-rst sec_ready", 32'(sec_ready), 32'd0);
        check("mid-rst sec_fill", 32'(sec_fill), 32'd0);
        check("mid-rst rd_data", 32'(rd_data), 32'd0);
        check("mid-rst overflow", 32'(overflow), 32'd0);
        check("mid-rst drop_cnt", 32'(drop_cnt), 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        for (int i = 0; i < SB; i++) begin
            exp_bytes[i] = pat(i, 4);
            send_byte(exp_bytes[i]);
        end
        wait_ready("post-rst", 10);
        check("post-rst fill", 32'(sec_fill), 32'd512);
        read_sector("post-rst data", SB);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
